// File: rtl/bool_lut_engine.sv
// rtl/bool_lut_engine.sv - writable truth-table LUT with streamed eval and ones-count sweep
//
// Holds an N_IN-input Boolean function as a 2^N_IN-bit truth table (bit i = f(i))
// and offers two ways of using it:
//   - streamed evaluation: in_vec in, registered out_f out, valid/ready on both sides
//   - exhaustive sweep: walks every LUT entry and reports how many are 1
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       eval request handshake, in_vec is the vector to evaluate
//   out_valid/out_ready     result handshake, out_f is f(in_vec) of the accepted request
//   cfg_we/cfg_addr/cfg_data  single-bit LUT write, honoured only while idle
//   start                   sweep request, sampled while idle
//   busy                    high while the sweep walks the table
//   done                    one-cycle pulse when the sweep completes
//   ones_count              number of ones found by the last completed sweep
module bool_lut_engine #(
  parameter int                      N_IN    = 5,
  parameter logic [(1<<N_IN)-1:0]    INIT_TT = 32'hAB03_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_f,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_count
);

  localparam int DEPTH = 1 << N_IN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [N_IN-1:0]  idx;
  logic [N_IN:0]    acc;
  logic [DEPTH-1:0] lut;
  logic             idle;
  logic             accept;

  assign idle     = (state == ST_IDLE);
  // start wins over an eval request arriving in the same idle cycle
  assign in_ready = idle & ~start & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == ST_SWEEP);
  assign done     = (state == ST_DONE);

  // Truth table; a write in the same cycle as an eval of the same entry is seen
  // by the eval as the old value because out_f samples lut before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut <= INIT_TT;
    end else if (cfg_we && idle) begin
      lut[cfg_addr] <= cfg_data;
    end
  end

  // Sweep controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      acc        <= '0;
      ones_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SWEEP;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ST_SWEEP: begin
          acc <= acc + (N_IN+1)'(lut[idx]);
          idx <= idx + N_IN'(1);
          // last entry is counted on this edge; idx wraps to 0 but is unused after
          if (idx == '1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ones_count <= acc;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Eval output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_f     <= lut[in_vec];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bool_lut_engine.sv
// tb/tb_bool_lut_engine.sv - randomized and directed bench for bool_lut_engine
module tb_bool_lut_engine;

  localparam int          N     = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] TT    = 32'hAB03_FFFF;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic         out_f;
  logic         cfg_we;
  logic [N-1:0] cfg_addr;
  logic         cfg_data;
  logic         start;
  logic         busy;
  logic         done;
  logic [N:0]   ones_count;

  int total = 0;
  int bad   = 0;

  // reference model: truth table, pending output, and sweep phase with cycles left
  logic [31:0] m_lut;
  logic        m_ov;
  logic        m_of;
  int          m_phase;   // 0 idle, 1 sweeping, 2 done cycle
  int          m_left;
  int          m_cnt;

  bool_lut_engine #(.N_IN(N), .INIT_TT(TT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ones_count (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lut   = TT;
    m_ov    = 1'b0;
    m_of    = 1'b0;
    m_phase = 0;
    m_left  = 0;
    m_cnt   = 0;
  endtask

  // one clock: check in_ready before the edge, advance the model on the edge,
  // check registered outputs on the following falling edge
  task automatic cyc();
    logic acc_m;
    logic idle_m;
    #1;
    check("in_ready", in_ready, (m_phase == 0) && !start && (!m_ov || out_ready));
    @(posedge clk);
    idle_m = (m_phase == 0);
    acc_m  = in_valid && idle_m && !start && (!m_ov || out_ready);
    if (acc_m) begin
      m_of = m_lut[in_vec];
      m_ov = 1'b1;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (cfg_we && idle_m) m_lut[cfg_addr] = cfg_data;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_left = DEPTH; end
      1: begin m_left--; if (m_left == 0) m_phase = 2; end
      default: begin m_phase = 0; m_cnt = $countones(m_lut); end
    endcase
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_f", out_f, m_of);
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    check("ones_count", ones_count, m_cnt);
  endtask

  task automatic quiet();
    in_valid = 0; out_ready = 1; cfg_we = 0; start = 0;
  endtask

  // start a sweep, optionally poking the LUT while busy; returns busy cycles seen
  task automatic run_sweep(input bit poke, output int nbusy);
    bit seen;
    start = 1;
    cyc();
    start = 0;
    nbusy = 0;
    seen  = 0;
    for (int t = 0; t < 200; t++) begin
      if (busy) nbusy++;
      if (done) begin seen = 1; break; end
      cfg_we   = poke && busy;
      cfg_addr = 5'd16;
      cfg_data = 1'b0;
      cyc();
    end
    cfg_we = 0;
    check("sweep_done_seen", seen, 1);
  endtask

  initial begin
    int nb;
    logic [31:0] tt_v;
    tt_v = TT;
    rst_n = 0; in_vec = '0; cfg_addr = '0; cfg_data = 0;
    quiet();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_f", out_f, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_count, 0);
    rst_n = 1;
    #1 check("rst_in_ready", in_ready, 1);

    // default sweep
    run_sweep(0, nb);
    check("sweep1_busy_cycles", nb, 32);
    cyc();
    check("sweep1_ones", ones_count, 23);

    // eval stream 0..31 at full rate
    for (int i = 0; i < 32; i++) begin
      in_valid = 1; in_vec = N'(i); out_ready = 1;
      cyc();
      check("stream_bit", out_f, tt_v[i]);
      if (i == 5'b10010) check("spot_10010", out_f, 0);
      if (i == 5'b11011) check("spot_11011", out_f, 1);
      if (i == 5'b10000) check("spot_10000", out_f, 1);
    end
    quiet();
    cyc();

    // backpressure
    in_valid = 1; in_vec = 5'b10100; out_ready = 0;
    cyc();
    in_vec = 5'd7;
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_in_ready", in_ready, 0);
      cyc();
      check("bp_valid", out_valid, 1);
      check("bp_f", out_f, 0);
    end
    in_valid = 0; out_ready = 1;
    cyc();
    check("bp_drained", out_valid, 0);
    #1 check("bp_ready_back", in_ready, 1);

    // same-cycle write and eval of entry 18
    in_valid = 1; in_vec = 5'd18; cfg_we = 1; cfg_addr = 5'd18; cfg_data = 1;
    cyc();
    check("wr_same_cycle_old", out_f, 0);
    cfg_we = 0;
    cyc();
    check("wr_reeval_new", out_f, 1);
    quiet();
    cyc();
    run_sweep(0, nb);
    cyc();
    check("sweep_after_wr", ones_count, 24);

    // restore entry 18, then start and eval together, cfg poked during sweep
    cfg_we = 1; cfg_addr = 5'd18; cfg_data = 0;
    cyc();
    quiet();
    in_valid = 1; in_vec = 5'd3; start = 1;
    #1 check("start_blocks_ready", in_ready, 0);
    run_sweep(1, nb);
    check("start_prio_no_out", out_valid, 0);
    cyc();
    check("ones_cfg_ignored", ones_count, 23);
    cyc();
    check("eval_after_done_valid", out_valid, 1);
    check("eval_after_done_f", out_f, 1);
    quiet();
    cyc();

    // LUT writes, reset mid-sweep, fresh sweep
    cfg_we = 1; cfg_addr = 5'd0; cfg_data = 0;
    cyc();
    cfg_addr = 5'd31;
    cyc();
    quiet();
    start = 1;
    cyc();
    start = 0;
    repeat (9) cyc();
    rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ones", ones_count, 0);
    model_reset();
    @(negedge clk);
    check("midrst_done_held", done, 0);
    rst_n = 1;
    run_sweep(0, nb);
    cyc();
    check("sweep_after_rst", ones_count, 23);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = N'($urandom_range(0, DEPTH - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = N'($urandom_range(0, DEPTH - 1));
      cfg_data  = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 39) == 0);
      cyc();
    end
    quiet();
    for (int i = 0; i < 100 && m_phase != 0; i++) cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
